// File: rtl/seq_magnitude_comparator_if.sv
// Handshake and operand/result bundle for the chunked magnitude comparator.
// The requester drives start/abort/a/b and the comparator returns status and result.
interface seq_magnitude_comparator_if #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);

    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_eq_b;
    logic             a_lt_b;
    logic             a_gt_b;
    logic [CW-1:0]    cycles;

    modport master (
        output start, abort, a, b,
        input  busy, done, a_eq_b, a_lt_b, a_gt_b, cycles
    );

    modport slave (
        input  start, abort, a, b,
        output busy, done, a_eq_b, a_lt_b, a_gt_b, cycles
    );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per cycle from the
// MSB end and stops at the first differing chunk. Signed mode uses offset-binary.
module seq_magnitude_comparator #(
    parameter int WIDTH  = 16,
    parameter int CHUNK  = 4,
    parameter int SIGNED = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    seq_magnitude_comparator_if.slave   bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0]    N_CW     = CW'(N);
    localparam logic [WIDTH-1:0] MSB_MASK = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}}
                                                          : {WIDTH{1'b0}};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    function automatic logic [WIDTH-1:0] to_offset(input logic [WIDTH-1:0] v);
        to_offset = v ^ MSB_MASK;
    endfunction

    state_t            state_r;
    state_t            state_nx_s;

    logic [WIDTH-1:0]  a_sh_r;
    logic [WIDTH-1:0]  b_sh_r;
    logic [CW-1:0]     idx_r;
    logic              busy_r;
    logic              done_r;
    logic              eq_r;
    logic              lt_r;
    logic              gt_r;
    logic [CW-1:0]     cyc_r;

    logic [WIDTH-1:0]  a_sh_nx_s;
    logic [WIDTH-1:0]  b_sh_nx_s;
    logic [CW-1:0]     idx_nx_s;
    logic              busy_nx_s;
    logic              done_nx_s;
    logic              eq_nx_s;
    logic              lt_nx_s;
    logic              gt_nx_s;
    logic [CW-1:0]     cyc_nx_s;

    logic [CHUNK-1:0]  top_a_s;
    logic [CHUNK-1:0]  top_b_s;
    logic              chunk_diff_s;
    logic              last_chunk_s;

    assign top_a_s      = a_sh_r[WIDTH-1 -: CHUNK];
    assign top_b_s      = b_sh_r[WIDTH-1 -: CHUNK];
    assign chunk_diff_s = (top_a_s != top_b_s);
    assign last_chunk_s = (idx_r == N_CW);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; abort wins over chunk resolution.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nx_s = CMP;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CMP: begin
                if (bus.abort || chunk_diff_s || last_chunk_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = CMP;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Next values for the datapath and the registered result/status outputs.
    always_comb begin
        a_sh_nx_s = a_sh_r;
        b_sh_nx_s = b_sh_r;
        idx_nx_s  = idx_r;
        busy_nx_s = busy_r;
        done_nx_s = 1'b0;
        eq_nx_s   = eq_r;
        lt_nx_s   = lt_r;
        gt_nx_s   = gt_r;
        cyc_nx_s  = cyc_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    a_sh_nx_s = to_offset(bus.a);
                    b_sh_nx_s = to_offset(bus.b);
                    idx_nx_s  = CW'(1'b1);
                    busy_nx_s = 1'b1;
                end else begin
                    busy_nx_s = 1'b0;
                end
            end
            CMP: begin
                if (bus.abort) begin
                    busy_nx_s = 1'b0;
                end else if (chunk_diff_s) begin
                    gt_nx_s   = (top_a_s > top_b_s);
                    lt_nx_s   = (top_a_s < top_b_s);
                    eq_nx_s   = 1'b0;
                    cyc_nx_s  = idx_r;
                    done_nx_s = 1'b1;
                    busy_nx_s = 1'b0;
                end else if (last_chunk_s) begin
                    eq_nx_s   = 1'b1;
                    lt_nx_s   = 1'b0;
                    gt_nx_s   = 1'b0;
                    cyc_nx_s  = idx_r;
                    done_nx_s = 1'b1;
                    busy_nx_s = 1'b0;
                end else begin
                    a_sh_nx_s = a_sh_r << CHUNK;
                    b_sh_nx_s = b_sh_r << CHUNK;
                    idx_nx_s  = idx_r + CW'(1'b1);
                    busy_nx_s = 1'b1;
                end
            end
            default: begin
                busy_nx_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; results reset to the equal state.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r <= {WIDTH{1'b0}};
            b_sh_r <= {WIDTH{1'b0}};
            idx_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            done_r <= 1'b0;
            eq_r   <= 1'b1;
            lt_r   <= 1'b0;
            gt_r   <= 1'b0;
            cyc_r  <= {CW{1'b0}};
        end else begin
            a_sh_r <= a_sh_nx_s;
            b_sh_r <= b_sh_nx_s;
            idx_r  <= idx_nx_s;
            busy_r <= busy_nx_s;
            done_r <= done_nx_s;
            eq_r   <= eq_nx_s;
            lt_r   <= lt_nx_s;
            gt_r   <= gt_nx_s;
            cyc_r  <= cyc_nx_s;
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.a_eq_b = eq_r;
    assign bus.a_lt_b = lt_r;
    assign bus.a_gt_b = gt_r;
    assign bus.cycles = cyc_r;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed bench: four comparator configurations share one stimulus stream; en masks
// which instances see start/abort so protocol tests can target a single instance.
module tb_seq_magnitude_comparator;
    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  en;

    int checks = 0;
    int errors = 0;

    // d0: C4 unsigned, d1: C4 signed, d2: C1 signed, d3: C16 unsigned
    seq_magnitude_comparator_if #(.WIDTH(16), .CHUNK(4))  if0 ();
    seq_magnitude_comparator_if #(.WIDTH(16), .CHUNK(4))  if1 ();
    seq_magnitude_comparator_if #(.WIDTH(16), .CHUNK(1))  if2 ();
    seq_magnitude_comparator_if #(.WIDTH(16), .CHUNK(16)) if3 ();

    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4),  .SIGNED(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(4),  .SIGNED(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(1),  .SIGNED(1)) u2 (.clk(clk), .rst(rst), .bus(if2));
    seq_magnitude_comparator #(.WIDTH(16), .CHUNK(16), .SIGNED(0)) u3 (.clk(clk), .rst(rst), .bus(if3));

    assign if0.start = start & en[0];  assign if0.abort = abort & en[0];
    assign if1.start = start & en[1];  assign if1.abort = abort & en[1];
    assign if2.start = start & en[2];  assign if2.abort = abort & en[2];
    assign if3.start = start & en[3];  assign if3.abort = abort & en[3];
    assign if0.a = a;  assign if0.b = b;
    assign if1.a = a;  assign if1.b = b;
    assign if2.a = a;  assign if2.b = b;
    assign if3.a = a;  assign if3.b = b;

    logic [3:0] busy_v, done_v, eq_v, lt_v, gt_v;
    logic [4:0] cyc_v [4];

    assign busy_v = {if3.busy,   if2.busy,   if1.busy,   if0.busy};
    assign done_v = {if3.done,   if2.done,   if1.done,   if0.done};
    assign eq_v   = {if3.a_eq_b, if2.a_eq_b, if1.a_eq_b, if0.a_eq_b};
    assign lt_v   = {if3.a_lt_b, if2.a_lt_b, if1.a_lt_b, if0.a_lt_b};
    assign gt_v   = {if3.a_gt_b, if2.a_gt_b, if1.a_gt_b, if0.a_gt_b};
    assign cyc_v[0] = 5'(if0.cycles);
    assign cyc_v[1] = 5'(if1.cycles);
    assign cyc_v[2] = 5'(if2.cycles);
    assign cyc_v[3] = 5'(if3.cycles);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the result fields of one instance; r: 0 eq, 1 lt, 2 gt.
    task automatic check_res(input string tag, input int d, input int r, input int c);
        check($sformatf("%s d%0d eq", tag, d), 32'(eq_v[d]), 32'(r == 0));
        check($sformatf("%s d%0d lt", tag, d), 32'(lt_v[d]), 32'(r == 1));
        check($sformatf("%s d%0d gt", tag, d), 32'(gt_v[d]), 32'(r == 2));
        check($sformatf("%s d%0d cycles", tag, d), 32'(cyc_v[d]), 32'(c));
    endtask

    // Starts all four instances, watches 20 cycles for done, then checks results.
    task automatic run(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input int r0, input int c0, input int r1, input int c1,
                       input int r2, input int c2, input int r3, input int c3);
        int er [4];
        int ec [4];
        int lat [4];
        int cnt [4];
        er  = '{r0, r1, r2, r3};
        ec  = '{c0, c1, c2, c3};
        lat = '{0, 0, 0, 0};
        cnt = '{0, 0, 0, 0};
        en = 4'hF; a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy after start"}, 32'(busy_v), 32'hF);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 4; d++) begin
                if (done_v[d]) begin
                    cnt[d]++;
                    if (lat[d] == 0) lat[d] = k;
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            check($sformatf("%s d%0d latency", tag, d), 32'(lat[d]), 32'(ec[d]));
            check($sformatf("%s d%0d done count", tag, d), 32'(cnt[d]), 32'd1);
            check_res(tag, d, er[d], ec[d]);
        end
    endtask

    // Waits (bounded) for d0 done after a start; returns latency or 0 on timeout.
    task automatic wait_d0(output int lat);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (done_v[0]) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int cnt;
        rst = 1'b1; start = 1'b0; abort = 1'b0; en = 4'hF; a = 16'h0000; b = 16'h0000;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 4; d++) check_res("reset", d, 0, 0);
        check("reset busy", 32'(busy_v), 32'h0);
        check("reset done", 32'(done_v), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("idle busy", 32'(busy_v), 32'h0);
        check("idle done", 32'(done_v), 32'h0);
        check_res("idle", 0, 0, 0);

        run("early",  16'hA123, 16'h5123, 2, 1,  1, 1,  1, 1,  2, 1);
        run("equal",  16'h1234, 16'h1234, 0, 4,  0, 4,  0, 16, 0, 1);
        run("lastlt", 16'h12F0, 16'h12F1, 1, 4,  1, 4,  1, 16, 1, 1);
        run("minneg", 16'h8000, 16'h0001, 2, 1,  1, 1,  1, 1,  2, 1);
        run("ffff",   16'hFFFF, 16'hFFFE, 2, 4,  2, 4,  2, 16, 2, 1);
        run("mid",    16'h0F00, 16'h0E00, 2, 2,  2, 2,  2, 8,  2, 1);
        run("sign",   16'h7FFF, 16'h8000, 1, 1,  2, 1,  2, 1,  1, 1);

        // start while busy is ignored
        en = 4'h1; a = 16'h0000; b = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                a = 16'hFFFF; b = 16'h0000; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_v[0]) begin
                cnt++;
                if (lat == 0) lat = k;
            end
        end
        check("busy start latency", 32'(lat), 32'd4);
        check("busy start done count", 32'(cnt), 32'd1);
        check_res("busy start", 0, 0, 4);
        check("busy start idle after", 32'(busy_v[0]), 32'h0);

        // back-to-back start on the done cycle
        a = 16'h0000; b = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_d0(lat);
        check("b2b first latency", 32'(lat), 32'd4);
        a = 16'h0001; b = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b accepted busy", 32'(busy_v[0]), 32'h1);
        check("b2b accepted done", 32'(done_v[0]), 32'h0);
        wait_d0(lat);
        check("b2b second latency", 32'(lat), 32'd4);
        check_res("b2b", 0, 2, 4);

        // abort mid-compare keeps the previous result and produces no done
        a = 16'h0000; b = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy", 32'(busy_v[0]), 32'h0);
        check("abort done", 32'(done_v[0]), 32'h0);
        check_res("abort hold", 0, 2, 4);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done_v[0]) cnt++;
        end
        check("abort no done", 32'(cnt), 32'd0);

        // abort together with start in idle: start wins
        a = 16'h0003; b = 16'h0003; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("start+abort busy", 32'(busy_v[0]), 32'h1);
        wait_d0(lat);
        check("start+abort latency", 32'(lat), 32'd4);
        check_res("start+abort", 0, 0, 4);

        // reset mid-compare, then a fresh start
        a = 16'h0000; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset busy", 32'(busy_v[0]), 32'h0);
        check("midreset done", 32'(done_v[0]), 32'h0);
        check_res("midreset", 0, 0, 0);
        run("fresh", 16'h1000, 16'h2000, 1, 1,  1, 1,  1, 3,  1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
